// File: rtl/fb_pkg.sv
// Shared types and constants for the NES frame-buffer line scheduler.
package fb_pkg;

  localparam int NES_W = 256;
  localparam int NES_H = 240;

  typedef logic [8:0] rgb9_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
  } fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    BLANK = 2'd3
  } sched_state_t;

  function automatic fb_addr_t mk_addr(input logic [7:0] y, input logic [7:0] x);
    fb_addr_t a;
    a.y = y;
    a.x = x;
    return a;
  endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// RD_LAT-deep tracker of issued reads: carries valid, pixel index and a zero-fill flag
// so the line buffer write lines up with the cycle ram_rdata is valid.
module fb_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue,
  input  logic       zero,
  input  logic [7:0] idx,
  output logic       fill_we,
  output logic       fill_zero,
  output logic [7:0] fill_addr
);

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] zro;
  logic [7:0]        ix [RD_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      zro <= '0;
      for (int i = 0; i < RD_LAT; i++) ix[i] <= '0;
    end else begin
      vld[0] <= issue;
      zro[0] <= zero;
      ix[0]  <= idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        zro[i] <= zro[i-1];
        ix[i]  <= ix[i-1];
      end
    end
  end

  assign fill_we   = vld[RD_LAT-1];
  assign fill_zero = zro[RD_LAT-1];
  assign fill_addr = ix[RD_LAT-1];

endmodule

// File: rtl/fb_line_scheduler.sv
// Shares the single-port NES frame RAM between display line prefetch and PPU pixel writes.
// Define FB_STATS_EN to add stall_cnt, a saturating count of PPU stall cycles.
module fb_line_scheduler
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FAIR_N = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_req,
  input  logic [7:0]  line_num,
  output logic        line_done,
  output logic        fill_we,
  output logic [7:0]  fill_addr,
  output logic [8:0]  fill_data,
  input  logic        ppu_valid,
  output logic        ppu_ready,
  input  logic [7:0]  ppu_x,
  input  logic [7:0]  ppu_y,
  input  logic [8:0]  ppu_rgb,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [8:0]  ram_wdata,
  input  logic [8:0]  ram_rdata,
  output logic        overrun,
`ifdef FB_STATS_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [7:0] H_LIM     = 8'(NES_H);
  localparam logic [7:0] X_LAST    = 8'(NES_W - 1);
  localparam logic [3:0] SLOT_LAST = 4'(FAIR_N - 1);

  sched_state_t state, state_nx;
  logic [7:0]   line_q, line_nx;
  logic [7:0]   rd_idx, idx_nx;
  logic [3:0]   slot_cnt, slot_nx;
  logic         pend_v;
  logic [7:0]   pend_num;
  logic [7:0]   req_num;
  logic         overrun_q;
  logic         line_done_q;
  logic         take, latch;
  logic         issue, issue_zero;
  logic         ppu_acc, wr_ok, fill_zero;
  fb_addr_t     addr;

  assign req_num = pend_v ? pend_num : line_num;
  // A request not consumed directly by IDLE this cycle goes to the one-entry pending slot.
  assign latch   = line_req && ((state != IDLE) || pend_v);

  always_comb begin
    state_nx   = state;
    line_nx    = line_q;
    idx_nx     = rd_idx;
    slot_nx    = slot_cnt;
    take       = 1'b0;
    issue      = 1'b0;
    issue_zero = 1'b0;
    ppu_acc    = 1'b0;
    case (state)
      IDLE: begin
        ppu_acc = ppu_valid;
        if (pend_v || line_req) begin
          take     = 1'b1;
          line_nx  = req_num;
          idx_nx   = 8'd0;
          slot_nx  = 4'd0;
          state_nx = (req_num < H_LIM) ? FETCH : BLANK;
        end
      end
      FETCH: begin
        slot_nx = (slot_cnt == SLOT_LAST) ? 4'd0 : slot_cnt + 4'd1;
        if ((slot_cnt == SLOT_LAST) && ppu_valid) begin
          ppu_acc = 1'b1;
        end else begin
          issue  = 1'b1;
          idx_nx = rd_idx + 8'd1;
          if (rd_idx == X_LAST) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        ppu_acc = ppu_valid;
        if (fill_we && !fill_zero && (fill_addr == X_LAST)) state_nx = IDLE;
      end
      BLANK: begin
        ppu_acc    = ppu_valid;
        issue      = 1'b1;
        issue_zero = 1'b1;
        idx_nx     = rd_idx + 8'd1;
        if (rd_idx == X_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ppu_valid/ppu_ready: a pixel transfers in any cycle where both are high; ppu_ready may
  // follow ppu_valid combinationally, and the PPU holds x/y/rgb while valid is high and ready low.
  assign ppu_ready = ppu_acc & reset_n;
  assign wr_ok     = ppu_ready && (ppu_y < H_LIM);
  assign ram_we    = wr_ok;
  assign ram_wdata = wr_ok ? ppu_rgb : 9'd0;

  always_comb begin
    addr = mk_addr(8'd0, 8'd0);
    if (issue && !issue_zero) addr = mk_addr(line_q, rd_idx);
    else if (wr_ok)           addr = mk_addr(ppu_y, ppu_x);
  end
  assign ram_addr = addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      line_q      <= '0;
      rd_idx      <= '0;
      slot_cnt    <= '0;
      pend_v      <= 1'b0;
      pend_num    <= '0;
      overrun_q   <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state       <= state_nx;
      line_q      <= line_nx;
      rd_idx      <= idx_nx;
      slot_cnt    <= slot_nx;
      line_done_q <= fill_we && (fill_addr == X_LAST);
      if (take && pend_v) pend_v <= 1'b0;
      if (latch) begin
        if (pend_v && !take) begin
          overrun_q <= 1'b1;
        end else begin
          pend_v   <= 1'b1;
          pend_num <= line_num;
        end
      end
    end
  end

  fb_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue     (issue),
    .zero      (issue_zero),
    .idx       (rd_idx),
    .fill_we   (fill_we),
    .fill_zero (fill_zero),
    .fill_addr (fill_addr)
  );

  assign fill_data = (fill_we && !fill_zero) ? ram_rdata : 9'd0;
  assign line_done = line_done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state;

`ifdef FB_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        stall_q <= '0;
    else if (line_done_q)                                stall_q <= '0;
    else if (ppu_valid && !ppu_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fb_line_scheduler.sv
// Directed bench for fb_line_scheduler: behavioural 1-cycle frame RAM, fill scoreboard, PPU driver.
module tb_fb_line_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_req = 1'b0;
  logic [7:0]  line_num = '0;
  logic        line_done;
  logic        fill_we;
  logic [7:0]  fill_addr;
  logic [8:0]  fill_data;
  logic        ppu_valid = 1'b0;
  logic        ppu_ready;
  logic [7:0]  ppu_x = '0;
  logic [7:0]  ppu_y = '0;
  logic [8:0]  ppu_rgb = '0;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [8:0]  ram_wdata;
  logic [8:0]  ram_rdata;
  logic        overrun;
  logic [1:0]  dbg_state;
`ifdef FB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fb_line_scheduler #(.RD_LAT(1), .FAIR_N(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_req  (line_req),
    .line_num  (line_num),
    .line_done (line_done),
    .fill_we   (fill_we),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .ppu_valid (ppu_valid),
    .ppu_ready (ppu_ready),
    .ppu_x     (ppu_x),
    .ppu_y     (ppu_y),
    .ppu_rgb   (ppu_rgb),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .overrun   (overrun),
`ifdef FB_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // Frame RAM model: synchronous write, one-cycle registered read.
  logic [8:0] mem [65536];
  logic [8:0] rdata_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata_q <= mem[ram_addr];
  end
  assign ram_rdata = rdata_q;

  function automatic logic [8:0] pix(input logic [7:0] y, input logic [7:0] x);
    return {y[2:0], x[5:0]};
  endfunction

  function automatic logic [8:0] rgb_of(input int n);
    return 9'((n * 7 + 3) & 9'h1FF);
  endfunction

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cnt = 0;
  int done_seen = 0;
  int done_cyc_last = 0;
  int ppu_acc = 0;
  int bad_rd = 0;
  logic blank_mon = 1'b0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard the line buffer writes and count events away from the clock edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (fill_we) begin
      if (exp_q.size() == 0) begin
        check("fill_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("fill", 32'({fill_addr, fill_data}), 32'(e));
      end
    end
    if (line_done) begin
      done_cnt++;
      done_cyc_last = cyc;
    end
    if (ppu_valid && ppu_ready) ppu_acc++;
    if (blank_mon && !ppu_valid && ram_addr != 16'h0) bad_rd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [7:0] y, input logic zero);
    for (int x = 0; x < 256; x++)
      exp_q.push_back({8'(x), zero ? 9'd0 : pix(y, 8'(x))});
  endtask

  task automatic send_req(input logic [7:0] n);
    line_req = 1'b1;
    line_num = n;
    req_cyc  = cyc;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n = 0;
    while (done_cnt == done_seen && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == done_seen) begin
      check(tag, 32'hFFFF_FFFF, 32'(exp_cyc));
    end else begin
      done_seen++;
      check(tag, 32'(done_cyc_last - req_cyc), 32'(exp_cyc));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base;
    for (int y = 0; y < 256; y++)
      for (int x = 0; x < 256; x++)
        mem[y * 256 + x] = pix(8'(y), 8'(x));

    // Reset state, with ppu_valid high to show ppu_ready stays low in reset.
    ppu_valid = 1'b1;
    ppu_y     = 8'd20;
    repeat (3) tick();
    check("rst_ppu_ready", 32'(ppu_ready), 32'd0);
    check("rst_ram_we",    32'(ram_we),    32'd0);
    check("rst_ram_addr",  32'(ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_fill",      32'({fill_we, fill_addr, fill_data}), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    ppu_valid = 1'b0;
    ppu_y     = 8'd0;
    reset_n   = 1'b1;
    repeat (2) tick();

    // 1: plain fetch of line 5.
    push_line(8'd5, 1'b0);
    check("t1_pix17", 32'(pix(8'd5, 8'd17)), 32'h151);
    send_req(8'd5);
    wait_done("t1_latency", 258);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    // 2: PPU streams writes to line 200 while line 10 is fetched.
    push_line(8'd10, 1'b0);
    ppu_acc = 0;
    ppu_y   = 8'd200;
    send_req(8'd10);
    for (int k = 1; k <= 341; k++) begin
      ppu_valid = 1'b1;
      ppu_x     = 8'(ppu_acc);
      ppu_rgb   = rgb_of(ppu_acc);
      tick();
    end
    ppu_valid = 1'b0;
    wait_done("t2_latency", 343);
    check("t2_ppu_accepts", 32'(ppu_acc), 32'd85);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);
    for (int x = 0; x < 85; x++)
      check("t2_ppu_mem", 32'(mem[200 * 256 + x]), 32'(rgb_of(x)));
    check("t2_mem_untouched", 32'(mem[200 * 256 + 85]), 32'(pix(8'd200, 8'd85)));
    repeat (3) tick();

    // 3: line 240 is below the visible area: zero fill, no reads.
    push_line(8'd240, 1'b1);
    bad_rd    = 0;
    blank_mon = 1'b1;
    send_req(8'd240);
    wait_done("t3_latency", 258);
    blank_mon = 1'b0;
    check("t3_no_reads", 32'(bad_rd), 32'd0);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    // 4: three requests during a fetch; one pending survives, the rest overrun.
    base = done_cnt;
    push_line(8'd0, 1'b0);
    push_line(8'd1, 1'b0);
    send_req(8'd0);
    repeat (4) tick();
    for (int i = 1; i <= 3; i++) begin
      line_req = 1'b1;
      line_num = 8'(i);
      tick();
    end
    line_req = 1'b0;
    wait_done("t4_line0", 258);
    wait_done("t4_line1", 516);
    check("t4_overrun", 32'(overrun), 32'd1);
    repeat (400) tick();
    check("t4_done_total", 32'(done_cnt - base), 32'd2);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: PPU writes in IDLE: off-screen dropped, on-screen passed through.
    ppu_valid = 1'b1;
    ppu_y     = 8'd250;
    ppu_x     = 8'd3;
    ppu_rgb   = 9'h1AB;
    @(negedge clk);
    check("t5_drop_ready", 32'(ppu_ready), 32'd1);
    check("t5_drop_we",    32'(ram_we),    32'd0);
    tick();
    ppu_y = 8'd20;
    @(negedge clk);
    check("t5_wr_ready", 32'(ppu_ready), 32'd1);
    check("t5_wr_we",    32'(ram_we),    32'd1);
    check("t5_wr_addr",  32'(ram_addr),  32'h1403);
    check("t5_wr_data",  32'(ram_wdata), 32'h1AB);
    tick();
    ppu_valid = 1'b0;
    repeat (2) tick();

    // 6: reset while rd_idx = 100, then a clean fetch of line 7.
    push_line(8'd3, 1'b0);
    send_req(8'd3);
    repeat (100) tick();
    ppu_valid = 1'b1;
    reset_n   = 1'b0;
    #1;
    check("t6_fill_we",   32'(fill_we),   32'd0);
    check("t6_line_done", 32'(line_done), 32'd0);
    check("t6_ram_we",    32'(ram_we),    32'd0);
    check("t6_ppu_ready", 32'(ppu_ready), 32'd0);
    check("t6_overrun",   32'(overrun),   32'd0);
    check("t6_state",     32'(dbg_state), 32'd0);
    exp_q.delete();
    base = done_cnt;
    repeat (5) tick();
    ppu_valid = 1'b0;
    reset_n   = 1'b1;
    repeat (300) tick();
    check("t6_no_done", 32'(done_cnt - base), 32'd0);
    done_seen = done_cnt;
    push_line(8'd7, 1'b0);
    send_req(8'd7);
    wait_done("t6_line7", 258);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
